// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, memory handshake, IR and redirects
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_wr,
    input  logic        br_taken,
    input  logic        jmp_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        nop,
    output logic        fetch_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [31:0]      pc_nx;
    logic [31:0]      ir_nx;
    logic             nop_nx;
    logic             err_nx;

    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;

    // Pure decodes of registered state; no controller input reaches an output.
    assign npc     = pc + 32'd4;
    assign op      = ir[31:26];
    assign funct   = ir[5:0];
    assign im_req  = (state == S_REQ);
    assign im_addr = pc;

    assign br_off     = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign br_target  = npc + br_off;
    assign jmp_target = {npc[31:28], ir[25:0], 2'b00};

    // Jump outranks branch when both are requested together.
    always_comb begin
        next_pc = npc;
        if (!jmp_n) begin
            next_pc = jmp_target;
        end else if (br_taken) begin
            next_pc = br_target;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_nx    = pc;
        ir_nx    = ir;
        nop_nx   = nop;
        err_nx   = fetch_err;
        unique case (state)
            S_RST: begin
                cnt_nx   = '0;
                nop_nx   = 1'b1;
                state_nx = S_REQ;
            end
            S_REQ: begin
                nop_nx = 1'b1;
                if (im_ack) begin
                    ir_nx    = im_rdata;
                    nop_nx   = 1'b0;
                    cnt_nx   = '0;
                    state_nx = S_VALID;
                end else if (cnt == CNT_MAX) begin
                    // Counter saturates; the request keeps asserting after the error.
                    err_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_VALID: begin
                if (pc_wr) begin
                    pc_nx    = next_pc;
                    nop_nx   = 1'b1;
                    state_nx = S_REQ;
                end
            end
            default: begin
                state_nx = S_RST;
                nop_nx   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RST;
            cnt       <= '0;
            pc        <= {RESET_PC[31:2], 2'b00};
            ir        <= '0;
            nop       <= 1'b1;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pc        <= {pc_nx[31:2], 2'b00};
            ir        <= ir_nx;
            nop       <= nop_nx;
            fetch_err <= err_nx;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the controller.
- Owns the PC and a handshake to instruction memory. Latches the fetched word into IR, then presents op/funct plus a nop/bubble flag to the controller.
- Applies sequential, branch (beq) and jump (j) redirects when the controller grants a PC write.
- Computes branch and jump targets internally from IR.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ACK_TIMEOUT, 16, max cycles S_REQ waits for im_ack before flagging fetch_err.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_wr  in  1  controller grant to advance PC (PCWr).
- br_taken  in  1  controller Branch ANDed with ALU zero; branch redirect request.
- jmp_n  in  1  active-low jump request (0 = take j target), same sense as controller JMPCTL.
- im_req  out  1  instruction-memory request.
- im_addr  out  32  word-aligned fetch address; equals pc while im_req=1.
- im_ack  in  1  memory has im_rdata valid this cycle.
- im_rdata  in  32  fetched instruction.
- pc  out  32  address of instruction in ir.
- npc  out  32  pc + 4.
- ir  out  32  current instruction.
- op  out  6  ir[31:26].
- funct  out  6  ir[5:0].
- nop  out  1  1 = ir not valid; controller must issue no writes.
- fetch_err  out  1  sticky; set on ack timeout.

Behaviour:
- Reset (rst=1 at edge; overrides everything, including mid-request):
  - pc=RESET_PC, ir=0, nop=1, fetch_err=0, im_req=0, timeout counter=0.
  - State goes to S_RST.
- S_RST (1 cycle): im_req=0; any im_ack ignored; goes to S_REQ.
- S_REQ:
  - im_req=1, im_addr=pc, nop=1.
  - On im_ack=1: ir<=im_rdata, nop<=0, counter<=0, go to S_VALID. Fetch latency is therefore ≥1 cycle after im_req rises.
  - Without ack: counter increments.
  - Counter reaching ACK_TIMEOUT-1 without ack sets fetch_err=1 and stays in S_REQ (request keeps asserting).
  - pc_wr, br_taken and jmp_n are ignored in this state.
- S_VALID:
  - im_req=0; ir, pc and nop=0 are held.
  - If pc_wr=0: stay (stall).
  - If pc_wr=1: pc<=next_pc, nop<=1, go to S_REQ. Fetch of the new PC begins next cycle.
- next_pc priority:
  - jmp_n=0: {npc[31:28], ir[25:0], 2'b00}.
  - Else br_taken=1: npc + {{14{ir[15]}}, ir[15:0], 2'b00}.
  - Else: npc.
  - Jump wins if jmp_n=0 and br_taken=1 are asserted together.
- Arithmetic: all 32-bit, modulo 2^32. pc=32'hFFFF_FFFC with pc_wr gives npc wrap to 0, with no error. pc[1:0] is always 00.
- Any im_ack outside S_REQ is ignored. ir never changes except on the accepting edge.
- Outputs are registered or pure decodes of registered state: op, funct and npc are combinational from ir/pc. No combinational path from pc_wr, br_taken or jmp_n to any output.

Test Plan:
- Reset then ack after 2 wait cycles with im_rdata=32'h3421_0005 (ori) -> im_addr=32'h0000_3000. nop=1 until the accepting edge, then nop=0, op=6'h0D, npc=32'h0000_3004.
- In S_VALID assert pc_wr=1, br_taken=0, jmp_n=1 -> next cycle pc=32'h0000_3004, nop=1, im_req=1.
- ir=32'h1022_FFFF (beq, offset -1) at pc=32'h0000_3008, br_taken=1, pc_wr=1 -> pc=32'h0000_3008 (npc 300C + FFFF_FFFC).
- ir=32'h0800_0C10 (j) at pc=32'h0000_3010, jmp_n=0 with br_taken=1 simultaneously -> pc=32'h0000_3040 (jump wins).
- Hold pc_wr=0 for 5 cycles in S_VALID while toggling im_ack -> ir, pc and nop unchanged; im_req=0.
- Assert rst while S_REQ waits with im_ack arriving the same cycle -> ir=0, pc=RESET_PC, im_req=0 for one cycle. Then withhold ack for 16 cycles -> fetch_err=1 and stays set until rst.
